rgb_to_gray_axis: RTL and testbench

Upstream stage of the Sobel edge-detection path. Accepts RGB888 video over AXI4-Stream, converts each pixel to 8-bit luma with fixed-point BT.601 weights, and emits the luma replicated on all three bytes so the edge detector can consume byte 0 directly. Includes a frame-structure monitor that checks line length, lines per frame and start-of-frame placement on the input stream, with sticky error flags and a frame counter.

---
 rtl/rgb_to_gray_axis_if.sv | 27 ++
 rtl/rgb_to_gray_axis.sv | 194 +++++++++++++++++++
 tb/tb_rgb_to_gray_axis.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rgb_to_gray_axis_if.sv
// AXI4-Stream video bundle used on both sides of the RGB-to-luma stage.
// Carries one pixel per beat, plus tlast (end of line) and tuser (start of frame).
interface rgb_to_gray_axis_if #(
  parameter int DATA_WIDTH = 24
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;
  logic                  tuser;

  modport master (
    output tvalid,
    output tdata,
    output tlast,
    output tuser,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    input  tlast,
    input  tuser,
    output tready
  );
endinterface

// File: rtl/rgb_to_gray_axis.sv
// RGB888 to BT.601 luma over AXI4-Stream. Three-stage pipeline; the Y value is replicated onto all bytes.
// A monitor on the input stream checks the frame structure and keeps sticky error flags and a frame counter.
module rgb_to_gray_axis #(
  parameter int IMAGE_WIDTH      = 640,
  parameter int IMAGE_HEIGHT     = 480,
  parameter int AXIS_TDATA_WIDTH = 24,
  parameter int COEF_R           = 77,
  parameter int COEF_G           = 150,
  parameter int COEF_B           = 29
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  rgb_to_gray_axis_if.slave     s_axis,
  rgb_to_gray_axis_if.master    m_axis,
  input  logic                  bypass,
  input  logic                  clr_err,
  output logic                  err_line_len,
  output logic                  err_frame_len,
  output logic                  err_sof,
  output logic [15:0]           frame_count
);

  localparam int DW = AXIS_TDATA_WIDTH;
  localparam int XW = $clog2(IMAGE_WIDTH) + 1;
  localparam int YW = $clog2(IMAGE_HEIGHT) + 1;

  localparam logic [7:0]    CR     = 8'(COEF_R);
  localparam logic [7:0]    CG     = 8'(COEF_G);
  localparam logic [7:0]    CB     = 8'(COEF_B);
  localparam logic [XW-1:0] X_MAX  = XW'(IMAGE_WIDTH);
  localparam logic [XW-1:0] X_LAST = XW'(IMAGE_WIDTH - 1);
  localparam logic [YW-1:0] Y_MAX  = YW'(IMAGE_HEIGHT);

  if (AXIS_TDATA_WIDTH != 24) begin : g_bad_width
    $error("rgb_to_gray_axis supports only a 24-bit stream");
  end
  if (COEF_R + COEF_G + COEF_B != 256) begin : g_bad_coef
    $error("rgb_to_gray_axis weights must sum to 256");
  end

  // ---------------------------------------------------------------------------
  // Handshake: the whole pipeline moves together whenever the output slot is free
  // ---------------------------------------------------------------------------
  logic ce;
  logic accept;

  assign ce            = m_axis.tready || !m_axis.tvalid;
  assign s_axis.tready = ce;
  assign accept        = s_axis.tvalid && ce;

  // ---------------------------------------------------------------------------
  // Stage 1: weighted products plus sideband
  // ---------------------------------------------------------------------------
  logic          s1_valid;
  logic [15:0]   s1_pr, s1_pg, s1_pb;
  logic          s1_last, s1_user, s1_bypass;
  logic [DW-1:0] s1_raw;

  // NOTE: datapath registers are reset along with the valids so that a
  // mid-frame reset leaves nothing stale for the output stage to present.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s1_valid  <= 1'b0;
      s1_pr     <= '0;
      s1_pg     <= '0;
      s1_pb     <= '0;
      s1_last   <= 1'b0;
      s1_user   <= 1'b0;
      s1_bypass <= 1'b0;
      s1_raw    <= '0;
    end else if (ce) begin
      s1_valid <= s_axis.tvalid;
      if (s_axis.tvalid) begin
        s1_pr     <= 16'(CR) * 16'(s_axis.tdata[23:16]);
        s1_pg     <= 16'(CG) * 16'(s_axis.tdata[15:8]);
        s1_pb     <= 16'(CB) * 16'(s_axis.tdata[7:0]);
        s1_last   <= s_axis.tlast;
        s1_user   <= s_axis.tuser;
        s1_bypass <= bypass;
        s1_raw    <= s_axis.tdata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: rounded sum; weights total 256 so the top byte cannot overflow
  // ---------------------------------------------------------------------------
  logic [16:0]   sum;
  logic [8:0]    unused_sum_bits;
  logic          s2_valid;
  logic [7:0]    s2_y;
  logic          s2_last, s2_user, s2_bypass;
  logic [DW-1:0] s2_raw;

  assign sum             = 17'(s1_pr) + 17'(s1_pg) + 17'(s1_pb) + 17'd128;
  assign unused_sum_bits = {sum[16], sum[7:0]};

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s2_valid  <= 1'b0;
      s2_y      <= '0;
      s2_last   <= 1'b0;
      s2_user   <= 1'b0;
      s2_bypass <= 1'b0;
      s2_raw    <= '0;
    end else if (ce) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_y      <= sum[15:8];
        s2_last   <= s1_last;
        s2_user   <= s1_user;
        s2_bypass <= s1_bypass;
        s2_raw    <= s1_raw;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: output registers, held stable while the sink stalls
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_axis.tvalid <= 1'b0;
      m_axis.tdata  <= '0;
      m_axis.tlast  <= 1'b0;
      m_axis.tuser  <= 1'b0;
    end else if (ce) begin
      m_axis.tvalid <= s2_valid;
      if (s2_valid) begin
        m_axis.tdata <= s2_bypass ? s2_raw : {3{s2_y}};
        m_axis.tlast <= s2_last;
        m_axis.tuser <= s2_user;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame-structure monitor on accepted input beats
  // ---------------------------------------------------------------------------
  logic [XW-1:0] x_cnt, x_base, x_nxt;
  logic [YW-1:0] y_cnt, y_base, y_nxt;
  logic          seen_frame;
  logic          line_evt, frame_evt, sof_evt;

  // NOTE: every signal assigned here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    x_base    = s_axis.tuser ? '0 : x_cnt;
    y_base    = s_axis.tuser ? '0 : y_cnt;
    x_nxt     = x_cnt;
    y_nxt     = y_cnt;
    line_evt  = 1'b0;
    frame_evt = 1'b0;
    sof_evt   = 1'b0;
    if (accept) begin
      y_nxt = y_base;
      if (s_axis.tuser) begin
        sof_evt   = (x_cnt != '0);
        frame_evt = seen_frame && (y_cnt != Y_MAX);
      end
      if (s_axis.tlast) begin
        line_evt = (x_base != X_LAST);
        x_nxt    = '0;
        y_nxt    = (y_base == Y_MAX) ? y_base : y_base + 1'b1;
      end else begin
        x_nxt = (x_base == X_MAX) ? x_base : x_base + 1'b1;
      end
    end
  end

  // A clear coinciding with a fresh error leaves the flag set.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      x_cnt         <= '0;
      y_cnt         <= '0;
      seen_frame    <= 1'b0;
      frame_count   <= '0;
      err_line_len  <= 1'b0;
      err_frame_len <= 1'b0;
      err_sof       <= 1'b0;
    end else begin
      x_cnt         <= x_nxt;
      y_cnt         <= y_nxt;
      err_line_len  <= (err_line_len  && !clr_err) || line_evt;
      err_frame_len <= (err_frame_len && !clr_err) || frame_evt;
      err_sof       <= (err_sof       && !clr_err) || sof_evt;
      if (accept && s_axis.tuser) begin
        seen_frame  <= 1'b1;
        frame_count <= frame_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_rgb_to_gray_axis.sv
// Self-checking bench for rgb_to_gray_axis: a reference queue predicts every output beat from
// the BT.601 arithmetic, plus directed checks of the frame monitor on a reduced image size.
module tb_rgb_to_gray_axis;

  localparam int W  = 16;
  localparam int H  = 8;
  localparam int CR = 77;
  localparam int CG = 150;
  localparam int CB = 29;

  typedef struct {
    logic [23:0] data;
    logic        last;
    logic        user;
    int          acc;
  } beat_t;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        bypass;
  logic        clr_err;
  logic        err_line_len, err_frame_len, err_sof;
  logic [15:0] frame_count;

  rgb_to_gray_axis_if #(.DATA_WIDTH(24)) s_if ();
  rgb_to_gray_axis_if #(.DATA_WIDTH(24)) m_if ();

  rgb_to_gray_axis #(
    .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .AXIS_TDATA_WIDTH(24),
    .COEF_R(CR), .COEF_G(CG), .COEF_B(CB)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .s_axis(s_if), .m_axis(m_if),
    .bypass(bypass), .clr_err(clr_err), .err_line_len(err_line_len),
    .err_frame_len(err_frame_len), .err_sof(err_sof), .frame_count(frame_count)
  );

  always #5 aclk = ~aclk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  bit          lat_check  = 1'b0;
  bit          rand_ready = 1'b0;
  beat_t       exp_q[$];
  logic [23:0] obs_q[$];
  int          obs_beats, obs_last, obs_user;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] ref_pix(input logic [23:0] d, input logic byp);
    int y;
    y = (CR * int'(d[23:16]) + CG * int'(d[15:8]) + CB * int'(d[7:0]) + 128) / 256;
    return byp ? d : {3{y[7:0]}};
  endfunction

  initial forever begin
    @(posedge aclk);
    cyc++;
  end

  initial forever begin
    @(posedge aclk);
    #1;
    if (rand_ready) m_if.tready = ($urandom_range(0, 2) != 0);
  end

  // Compare process: scoreboard pop on output handshakes, push on input accepts.
  initial begin
    beat_t       e;
    bit          held_v = 1'b0;
    logic [25:0] held   = '0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        exp_q.delete();
        held_v = 1'b0;
      end else begin
        if (held_v) begin
          check("hold_valid", m_if.tvalid, 1'b1);
          check("hold_data", {m_if.tdata, m_if.tlast, m_if.tuser}, held);
        end
        held_v = m_if.tvalid && !m_if.tready;
        held   = {m_if.tdata, m_if.tlast, m_if.tuser};
        if (m_if.tvalid && m_if.tready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", m_if.tvalid, 1'b0);
          end else begin
            e = exp_q.pop_front();
            check("out_data", m_if.tdata, e.data);
            check("out_last", m_if.tlast, e.last);
            check("out_user", m_if.tuser, e.user);
            if (lat_check) check("latency", cyc - e.acc, 2);
            obs_q.push_back(m_if.tdata);
            obs_beats++;
            if (m_if.tlast) obs_last++;
            if (m_if.tuser) obs_user++;
          end
        end
        if (s_if.tvalid && s_if.tready) begin
          e.data = ref_pix(s_if.tdata, bypass);
          e.last = s_if.tlast;
          e.user = s_if.tuser;
          e.acc  = cyc + 1;
          exp_q.push_back(e);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic send_beat(input logic [23:0] d, input logic last, input logic user,
                           input logic byp, input logic clr);
    int n = 0;
    s_if.tdata  = d;
    s_if.tlast  = last;
    s_if.tuser  = user;
    bypass      = byp;
    clr_err     = clr;
    s_if.tvalid = 1'b1;
    @(negedge aclk);
    while (!s_if.tready && n < 200) begin
      @(negedge aclk);
      n++;
    end
    check("send_accept", s_if.tready, 1'b1);
    @(posedge aclk);
    #1;
    s_if.tvalid = 1'b0;
    clr_err     = 1'b0;
  endtask

  task automatic send_line(input int len, input bit first_user, input bit clr_on_last);
    for (int x = 0; x < len; x++)
      send_beat($urandom_range(0, 24'hFFFFFF), x == len - 1, first_user && x == 0, 1'b0,
                clr_on_last && x == len - 1);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(posedge aclk);
    #1;
    clr_err = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    rand_ready  = 1'b0;
    m_if.tready = 1'b1;
    while ((exp_q.size() != 0 || m_if.tvalid) && n < 500) begin
      @(negedge aclk);
      n++;
    end
    check("drain_done", exp_q.size(), 0);
    idle(1);
  endtask

  task automatic check_errs(input string tag, input logic l, input logic f, input logic s);
    check({tag, "_err_line_len"}, err_line_len, l);
    check({tag, "_err_frame_len"}, err_frame_len, f);
    check({tag, "_err_sof"}, err_sof, s);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn     = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = 1'b0;
    m_if.tready = 1'b1;
    bypass      = 1'b0;
    clr_err     = 1'b0;

    // Reset values
    idle(3);
    check("rst_m_tvalid", m_if.tvalid, 1'b0);
    check("rst_m_tdata", m_if.tdata, 24'h0);
    check("rst_m_tlast", m_if.tlast, 1'b0);
    check("rst_m_tuser", m_if.tuser, 1'b0);
    check_errs("rst", 1'b0, 1'b0, 1'b0);
    check("rst_frame_count", frame_count, 16'd0);
    aresetn = 1'b1;
    idle(1);
    check("post_rst_s_tready", s_if.tready, 1'b1);

    // Directed pixels, then bypass including per-beat toggling
    lat_check = 1'b1;
    obs_q.delete();
    send_beat(24'hFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0);
    send_beat(24'h000000, 1'b0, 1'b0, 1'b0, 1'b0);
    send_beat(24'hFF0000, 1'b0, 1'b0, 1'b0, 1'b0);
    send_beat(24'h00FF00, 1'b0, 1'b0, 1'b0, 1'b0);
    send_beat(24'h0000FF, 1'b0, 1'b0, 1'b0, 1'b0);
    send_beat(24'h123456, 1'b0, 1'b0, 1'b1, 1'b0);
    send_beat(24'h123456, 1'b0, 1'b0, 1'b0, 1'b0);
    send_beat(24'hABCDEF, 1'b0, 1'b0, 1'b1, 1'b0);
    send_beat(24'h00FF00, 1'b0, 1'b0, 1'b1, 1'b0);
    send_beat(24'h00FF00, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();
    lat_check = 1'b0;
    check("lit_white", obs_q[0], 24'hFFFFFF);
    check("lit_black", obs_q[1], 24'h000000);
    check("lit_red", obs_q[2], 24'h4D4D4D);
    check("lit_green", obs_q[3], 24'h959595);
    check("lit_blue", obs_q[4], 24'h1D1D1D);
    check("lit_bypass", obs_q[5], 24'h123456);
    check("lit_nobypass", obs_q[6], 24'h2E2E2E);
    check("lit_bypass2", obs_q[7], 24'hABCDEF);
    check("lit_bypass3", obs_q[8], 24'h00FF00);
    check("lit_green2", obs_q[9], 24'h959595);

    // Asynchronous reset mid-cycle with a stalled, full pipeline
    m_if.tready = 1'b0;
    send_beat(24'hFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0);
    send_beat(24'h0000FF, 1'b0, 1'b1, 1'b0, 1'b0);
    send_beat(24'h00FF00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("pre_rst_m_tvalid", m_if.tvalid, 1'b1);
    check("pre_rst_s_tready", s_if.tready, 1'b0);
    check("pre_rst_frame_count", frame_count, 16'd2);
    check("pre_rst_err_sof", err_sof, 1'b1);
    @(posedge aclk);
    #3;
    aresetn = 1'b0;
    #1;
    check("async_m_tvalid", m_if.tvalid, 1'b0);
    check("async_m_tdata", m_if.tdata, 24'h0);
    check("async_frame_count", frame_count, 16'd0);
    check_errs("async", 1'b0, 1'b0, 1'b0);
    idle(2);
    m_if.tready = 1'b1;
    aresetn     = 1'b1;
    idle(5);
    check("post_rst_no_output", m_if.tvalid, 1'b0);
    check("post_rst_s_tready2", s_if.tready, 1'b1);

    // Full frame with random gaps and random sink backpressure
    obs_beats  = 0;
    obs_last   = 0;
    obs_user   = 0;
    rand_ready = 1'b1;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        send_beat($urandom_range(0, 24'hFFFFFF), x == W - 1, x == 0 && y == 0,
                  $urandom_range(0, 7) == 0, 1'b0);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
    end
    drain();
    check("frame_beats", obs_beats, W * H);
    check("frame_tlast", obs_last, H);
    check("frame_tuser", obs_user, 1);
    check_errs("frame", 1'b0, 1'b0, 1'b0);
    check("frame_count_1", frame_count, 16'd1);

    // Short line, clear, and clear coinciding with another short line
    send_line(W - 1, 1'b1, 1'b0);
    idle(2);
    check_errs("short1", 1'b1, 1'b0, 1'b0);
    check("frame_count_2", frame_count, 16'd2);
    pulse_clr();
    idle(1);
    check("clr_err_line_len", err_line_len, 1'b0);
    send_line(W - 1, 1'b0, 1'b1);
    idle(2);
    check("clr_coincident_line_len", err_line_len, 1'b1);
    pulse_clr();
    idle(1);
    check_errs("cleared", 1'b0, 1'b0, 1'b0);

    // Frame one line short, then tuser away from x=0
    for (int l = 0; l < H - 3; l++) send_line(W, 1'b0, 1'b0);
    idle(2);
    check_errs("short_frame_pre", 1'b0, 1'b0, 1'b0);
    send_beat(24'h102030, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);
    check_errs("short_frame", 1'b0, 1'b1, 1'b0);
    check("frame_count_3", frame_count, 16'd3);
    for (int x = 1; x < 5; x++) send_beat(24'h405060, 1'b0, 1'b0, 1'b0, 1'b0);
    send_beat(24'h708090, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);
    check("sof_err_sof", err_sof, 1'b1);
    check("frame_count_4", frame_count, 16'd4);
    pulse_clr();
    idle(1);
    check_errs("final_clear", 1'b0, 1'b0, 1'b0);

    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
